// File: rtl/wave_pkg.sv
// Shared definitions for the waveform pattern player.
// Holds the default sizing, the pattern-entry layout and the FSM state type.
// The entry struct uses the default widths; parameterised modules slice
// wr_data directly with the same {hold, value} ordering.
package wave_pkg;

    localparam int NSIG_DEF  = 5;
    localparam int DEPTH_DEF = 16;
    localparam int HOLDW_DEF = 4;

    // One pattern-table entry: value is driven for hold+1 cycles.
    typedef struct packed {
        logic [HOLDW_DEF-1:0] hold;
        logic [NSIG_DEF-1:0]  value;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/wave_pattern_mem.sv
// Pattern storage for wave_pattern_player.
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational from raddr)
module wave_pattern_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wave_pattern_player.sv
// Waveform pattern player.
// Plays a table of {hold, value} entries onto sig_out; each entry is held for
// hold+1 cycles. Playback covers entries 0..length-1, optionally looping.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data - pattern table write (ignored while busy)
//   start, stop        - begin playback / abort (stop wins)
//   loop_en, length    - latched at start: wrap enable and entry count
//   sig_out            - registered waveform values
//   busy               - high while an entry is on sig_out
//   done               - one-cycle pulse on non-looping completion
//   step_idx           - entry currently driven
module wave_pattern_player
    import wave_pkg::*;
#(
    parameter int NSIG  = NSIG_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int HOLDW = HOLDW_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NSIG+HOLDW-1:0]      wr_data,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic [$clog2(DEPTH):0]     length,
    output logic [NSIG-1:0]            sig_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = NSIG + HOLDW;
    localparam logic [AW:0]   LEN_ONE = 1;
    localparam logic [AW-1:0] IDX_ONE = 1;

    state_t           state, state_n;
    logic [NSIG-1:0]  sig_n;
    logic             busy_n, done_n;
    logic [AW-1:0]    idx_n;
    logic [HOLDW-1:0] hold_cnt, hold_cnt_n;
    logic [HOLDW-1:0] cur_hold, cur_hold_n;   // hold of the entry on sig_out
    logic [AW:0]      len_q, len_n;
    logic             loop_q, loop_n;
    logic             last_entry;

    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_data;

    wave_pattern_mem #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en && !busy),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
            hold_cnt <= '0;
            cur_hold <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            state    <= state_n;
            sig_out  <= sig_n;
            busy     <= busy_n;
            done     <= done_n;
            step_idx <= idx_n;
            hold_cnt <= hold_cnt_n;
            cur_hold <= cur_hold_n;
            len_q    <= len_n;
            loop_q   <= loop_n;
        end
    end

    always_comb begin
        state_n    = state;
        sig_n      = sig_out;
        busy_n     = busy;
        done_n     = 1'b0;
        idx_n      = step_idx;
        hold_cnt_n = hold_cnt;
        cur_hold_n = cur_hold;
        len_n      = len_q;
        loop_n     = loop_q;
        rd_addr    = '0;
        last_entry = ({1'b0, step_idx} == (len_q - LEN_ONE));

        if (stop) begin
            state_n    = IDLE;
            sig_n      = '0;
            busy_n     = 1'b0;
            idx_n      = '0;
            hold_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_n = 1'b1;
                        end else begin
                            // rd_addr is already 0: load entry 0 directly.
                            state_n    = PLAY;
                            len_n      = length;
                            loop_n     = loop_en;
                            sig_n      = rd_data[NSIG-1:0];
                            cur_hold_n = rd_data[W-1:NSIG];
                            busy_n     = 1'b1;
                            idx_n      = '0;
                            hold_cnt_n = '0;
                        end
                    end
                end
                PLAY: begin
                    if (hold_cnt == cur_hold) begin
                        if (last_entry && !loop_q) begin
                            state_n    = IDLE;
                            sig_n      = '0;
                            busy_n     = 1'b0;
                            done_n     = 1'b1;
                            idx_n      = '0;
                            hold_cnt_n = '0;
                        end else begin
                            // Look up the following entry so it appears
                            // with no gap cycle.
                            rd_addr    = last_entry ? '0 : (step_idx + IDX_ONE);
                            idx_n      = rd_addr;
                            sig_n      = rd_data[NSIG-1:0];
                            cur_hold_n = rd_data[W-1:NSIG];
                            hold_cnt_n = '0;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_pattern_player.sv
module tb_wave_pattern_player;
  import wave_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [4:0] length;
  logic [4:0] sig_out;
  logic       busy;
  logic       done;
  logic [3:0] step_idx;

  int vec_count = 0;
  int err_count = 0;

  wave_pattern_player dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .length   (length),
    .sig_out  (sig_out),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] mk_entry(input int h, input int v);
    entry_t e;
    e.hold  = 4'(h);
    e.value = 5'(v);
    return e;
  endfunction

  task automatic write_entry(input int a, input int h, input int v);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = mk_entry(h, v);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0;
    #1;
    vec_count++;
    if ({sig_out, busy, done, step_idx} !== 11'd0) begin
      err_count++;
      $display("FAIL reset_outputs: got sig=%b busy=%b done=%b idx=%0d, want all 0",
               sig_out, busy, done, step_idx);
    end
    #13 rst_n = 1'b1;
  endtask

  // entries 0:{0,A} 1:{2,B}, length 2, no loop
  task automatic test_one_shot();
    logic [4:0] e_sig [6];
    logic       e_busy [6];
    logic       e_done [6];
    logic [3:0] e_idx [6];
    e_sig  = '{5'b00001, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    e_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e_idx  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    write_entry(0, 0, 5'b00001);
    write_entry(1, 2, 5'b00010);
    length = 5'd2; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vec_count++;
      if (sig_out !== e_sig[i] || busy !== e_busy[i] || done !== e_done[i] || step_idx !== e_idx[i]) begin
        err_count++;
        $display("FAIL one_shot[%0d]: got sig=%b busy=%b done=%b idx=%0d, want sig=%b busy=%b done=%b idx=%0d",
                 i, sig_out, busy, done, step_idx, e_sig[i], e_busy[i], e_done[i], e_idx[i]);
      end
      tick();
    end
  endtask

  // start pulses during PLAY must not disturb the sequence
  task automatic test_start_ignored();
    logic [4:0] e_sig [6];
    logic       e_done [6];
    e_sig  = '{5'b00001, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    length = 5'd2; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 1 || i == 2);
      vec_count++;
      if (sig_out !== e_sig[i] || done !== e_done[i]) begin
        err_count++;
        $display("FAIL start_ignored[%0d]: got sig=%b done=%b, want sig=%b done=%b",
                 i, sig_out, done, e_sig[i], e_done[i]);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_loop_stop();
    logic [4:0] exp_s;
    length = 5'd2; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; loop_en = 1'b0;  // latched value must keep looping
    for (int i = 0; i < 10; i++) begin
      exp_s = (i % 4 == 0) ? 5'b00001 : 5'b00010;
      vec_count++;
      if (sig_out !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        err_count++;
        $display("FAIL loop[%0d]: got sig=%b busy=%b done=%b, want sig=%b busy=1 done=0",
                 i, sig_out, busy, done, exp_s);
      end
      if (i < 9) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vec_count++;
    if (sig_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
      err_count++;
      $display("FAIL stop_mid_entry: got sig=%b busy=%b done=%b idx=%0d, want 0/0/0/0",
               sig_out, busy, done, step_idx);
    end
    tick();
    vec_count++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      err_count++;
      $display("FAIL after_stop: got busy=%b done=%b, want busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_zero_length();
    length = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    vec_count++;
    if (done !== 1'b1 || busy !== 1'b0 || sig_out !== 5'd0) begin
      err_count++;
      $display("FAIL zero_len_pulse: got done=%b busy=%b sig=%b, want done=1 busy=0 sig=0",
               done, busy, sig_out);
    end
    tick();
    vec_count++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL zero_len_after: got done=%b busy=%b, want done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_full_length();
    int busy_cnt = 0;
    int done_cnt = 0;
    bit finished = 0;
    for (int a = 0; a < 16; a++) write_entry(a, 15, a + 1);
    length = 5'd16; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      if (busy) begin
        vec_count++;
        if (step_idx !== 4'(busy_cnt / 16) || sig_out !== 5'(busy_cnt / 16 + 1)) begin
          err_count++;
          $display("FAIL full_step[%0d]: got idx=%0d sig=%b, want idx=%0d sig=%b",
                   busy_cnt, step_idx, sig_out, busy_cnt / 16, 5'(busy_cnt / 16 + 1));
        end
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        finished = 1;
      end
      tick();
    end
    vec_count++;
    if (!finished) begin
      err_count++;
      $display("FAIL full_timeout: done not seen within 300 cycles, busy_cnt=%0d", busy_cnt);
    end
    vec_count++;
    if (busy_cnt != 256 || done_cnt != 1) begin
      err_count++;
      $display("FAIL full_counts: got busy=%0d done=%0d, want busy=256 done=1", busy_cnt, done_cnt);
    end
    vec_count++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL full_after: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid_play();
    write_entry(0, 0, 5'b00001);
    write_entry(1, 2, 5'b00010);
    length = 5'd2; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // write attempt while busy must be dropped
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = mk_entry(0, 5'b11111);
    tick();
    wr_en = 1'b0;
    vec_count++;
    if (sig_out !== 5'b00010 || busy !== 1'b1 || step_idx !== 4'd1) begin
      err_count++;
      $display("FAIL pre_reset_entry1: got sig=%b busy=%b idx=%0d, want 00010/1/1",
               sig_out, busy, step_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    vec_count++;
    if (sig_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
      err_count++;
      $display("FAIL async_reset: got sig=%b busy=%b done=%b idx=%0d, want all 0",
               sig_out, busy, done, step_idx);
    end
    tick();
    #3 rst_n = 1'b1;
    length = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    vec_count++;
    if (sig_out !== 5'b00001 || busy !== 1'b1) begin
      err_count++;
      $display("FAIL replay_entry0: got sig=%b busy=%b, want 00001/1", sig_out, busy);
    end
    tick();
    vec_count++;
    if (sig_out !== 5'b00010 || step_idx !== 4'd1) begin
      err_count++;
      $display("FAIL replay_entry1: got sig=%b idx=%0d, want 00010/1", sig_out, step_idx);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_start_stop_together();
    length = 5'd2; loop_en = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    vec_count++;
    if (busy !== 1'b0 || done !== 1'b0 || sig_out !== 5'd0) begin
      err_count++;
      $display("FAIL start_stop_idle: got busy=%b done=%b sig=%b, want 0/0/0", busy, done, sig_out);
    end
    tick();
    vec_count++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      err_count++;
      $display("FAIL start_stop_after: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_start_ignored();
    test_loop_stop();
    test_zero_length();
    test_full_length();
    test_reset_mid_play();
    test_start_stop_together();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
